// File: rtl/core_mem_pkg.sv
// Shared definitions for the core memory responder: data widths, counter
// width, data-port FSM state encoding and the fetch half-word select.
package core_mem_pkg;

  localparam int WORD_W = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_BUSY = 2'd1,
    DS_RESP = 2'd2
  } data_state_e;

  // Pick the 32-bit instruction out of a 64-bit word (hi=1 -> upper half).
  function automatic logic [INST_W-1:0] inst_half(input logic [WORD_W-1:0] word,
                                                  input logic              hi);
    if (hi) begin
      inst_half = word[WORD_W-1:INST_W];
    end else begin
      inst_half = word[INST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/core_mem_array.sv
// 64-bit x 2^ADDR_WIDTH word array with two registered read ports (fetch,
// data) and one write port. Reads see the contents from before a write that
// lands on the same clock edge. Storage is not cleared by rst; only the read
// registers are.
module core_mem_array
  import core_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_idx,
  output logic [WORD_W-1:0]     fetch_word,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [WORD_W-1:0]     rd_word,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [WORD_W-1:0]     wr_word
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] fetch_word_r;
  logic [WORD_W-1:0] rd_word_r;

  // Write port; storage survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_word;
    end
  end

  // Fetch read register, updated only when the fetch tracker loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_word_r <= {WORD_W{1'b0}};
    end else if (fetch_en) begin
      fetch_word_r <= mem_r[fetch_idx];
    end
  end

  // Data read register, held between reads so writes never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_r <= {WORD_W{1'b0}};
    end else if (rd_en) begin
      rd_word_r <= mem_r[rd_idx];
    end
  end

  assign fetch_word = fetch_word_r;
  assign rd_word    = rd_word_r;

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the core: a fetch tracker serving 32-bit
// instructions after INST_LATENCY cycles, and a data-port FSM answering each
// request with a single ready pulse after DATA_LATENCY cycles. Both ports
// share one word array and run concurrently.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int INST_LATENCY = 1,
  parameter int DATA_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       inst_mem_addr,
  input  logic              inst_addr_valid,
  output logic              inst_mem_valid,
  output logic [INST_W-1:0] inst_mem_data,
  input  logic [63:0]       data_mem_addr,
  input  logic              data_mem_addr_valid,
  input  logic              data_mem_rw,
  input  logic [WORD_W-1:0] data_mem_data_w,
  output logic [WORD_W-1:0] data_mem_data_r,
  output logic              data_mem_ready
);

  localparam int IDX_LO = 3;
  localparam int IDX_HI = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] INST_RELOAD = CNT_W'(INST_LATENCY - 1);
  localparam logic [CNT_W-1:0] DATA_RELOAD = CNT_W'((DATA_LATENCY > 1) ? DATA_LATENCY - 2 : 0);

  // ---------------- fetch tracker ----------------
  logic                  cap_valid_r;
  logic [63:0]           cap_addr_r;
  logic [CNT_W-1:0]      inst_cnt_r;
  logic                  inst_loaded_r;
  logic                  new_fetch_s;
  logic                  inst_load_s;
  logic [ADDR_WIDTH-1:0] fetch_idx_s;
  logic [WORD_W-1:0]     fetch_word_s;

  // Detect a new fetch and decide when the instruction register loads; the
  // load lands on the edge where the counter reaches zero.
  always_comb begin
    new_fetch_s = inst_addr_valid & (~cap_valid_r | (inst_mem_addr != cap_addr_r));
    if (new_fetch_s) begin
      inst_load_s = (INST_RELOAD == {CNT_W{1'b0}});
      fetch_idx_s = inst_mem_addr[IDX_HI:IDX_LO];
    end else begin
      inst_load_s = cap_valid_r & (inst_cnt_r == CNT_W'(1));
      fetch_idx_s = cap_addr_r[IDX_HI:IDX_LO];
    end
  end

  // Capture the fetch address and count the latency down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_r   <= 1'b0;
      cap_addr_r    <= 64'd0;
      inst_cnt_r    <= {CNT_W{1'b0}};
      inst_loaded_r <= 1'b0;
    end else if (new_fetch_s) begin
      cap_valid_r   <= 1'b1;
      cap_addr_r    <= inst_mem_addr;
      inst_cnt_r    <= INST_RELOAD;
      inst_loaded_r <= inst_load_s;
    end else begin
      if (inst_cnt_r != {CNT_W{1'b0}}) begin
        inst_cnt_r <= inst_cnt_r - CNT_W'(1);
      end
      if (inst_load_s) begin
        inst_loaded_r <= 1'b1;
      end
    end
  end

  // Address compare is live so valid falls the same cycle the PC moves.
  assign inst_mem_valid = cap_valid_r & (inst_cnt_r == {CNT_W{1'b0}}) & inst_loaded_r &
                          inst_addr_valid & (inst_mem_addr == cap_addr_r);
  assign inst_mem_data  = inst_half(fetch_word_s, cap_addr_r[2]);

  // ---------------- data port FSM ----------------
  data_state_e           state_r;
  data_state_e           state_nxt_s;
  logic [CNT_W-1:0]      data_cnt_r;
  logic [ADDR_WIDTH-1:0] dreq_idx_r;
  logic                  dreq_rw_r;
  logic [WORD_W-1:0]     dreq_wdata_r;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] rd_idx_s;
  logic                  wr_en_s;

  // Next state; reads are issued on the transition into RESP.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    rd_idx_s    = dreq_idx_r;
    case (state_r)
      DS_IDLE: begin
        rd_idx_s = data_mem_addr[IDX_HI:IDX_LO];
        if (data_mem_addr_valid) begin
          if (DATA_RELOAD == {CNT_W{1'b0}} && DATA_LATENCY == 1) begin
            state_nxt_s = DS_RESP;
            rd_en_s     = ~data_mem_rw;
          end else begin
            state_nxt_s = DS_BUSY;
          end
        end else begin
          state_nxt_s = DS_IDLE;
        end
      end
      DS_BUSY: begin
        if (!data_mem_addr_valid) begin
          state_nxt_s = DS_IDLE;
        end else if (data_cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = DS_RESP;
          rd_en_s     = ~dreq_rw_r;
        end else begin
          state_nxt_s = DS_BUSY;
        end
      end
      DS_RESP: begin
        state_nxt_s = DS_IDLE;
      end
      default: begin
        state_nxt_s = DS_IDLE;
      end
    endcase
  end

  // State register, request latch and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= DS_IDLE;
      data_cnt_r   <= {CNT_W{1'b0}};
      dreq_idx_r   <= {ADDR_WIDTH{1'b0}};
      dreq_rw_r    <= 1'b0;
      dreq_wdata_r <= {WORD_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == DS_IDLE && data_mem_addr_valid) begin
        dreq_idx_r   <= data_mem_addr[IDX_HI:IDX_LO];
        dreq_rw_r    <= data_mem_rw;
        dreq_wdata_r <= data_mem_data_w;
        data_cnt_r   <= DATA_RELOAD;
      end else if (state_r == DS_BUSY && data_cnt_r != {CNT_W{1'b0}}) begin
        data_cnt_r <= data_cnt_r - CNT_W'(1);
      end
    end
  end

  // A reset arriving in RESP suppresses both the commit and the pulse.
  assign wr_en_s        = (state_r == DS_RESP) & dreq_rw_r & ~rst;
  assign data_mem_ready = (state_r == DS_RESP) & ~rst;

  core_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (inst_load_s),
    .fetch_idx  (fetch_idx_s),
    .fetch_word (fetch_word_s),
    .rd_en      (rd_en_s),
    .rd_idx     (rd_idx_s),
    .rd_word    (data_mem_data_r),
    .wr_en      (wr_en_s),
    .wr_idx     (dreq_idx_r),
    .wr_word    (dreq_wdata_r)
  );

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder with default parameters
// (ADDR_WIDTH=12, INST_LATENCY=1, DATA_LATENCY=2).
module tb_core_mem_responder;

  localparam int AW       = 12;
  localparam int INST_LAT = 1;
  localparam int DATA_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_mem_addr;
  logic        inst_addr_valid;
  logic        inst_mem_valid;
  logic [31:0] inst_mem_data;
  logic [63:0] data_mem_addr;
  logic        data_mem_addr_valid;
  logic        data_mem_rw;
  logic [63:0] data_mem_data_w;
  logic [63:0] data_mem_data_r;
  logic        data_mem_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model [int];
  logic [63:0] exp_q [$];
  logic [63:0] last_rd = 64'd0;

  core_mem_responder #(
    .ADDR_WIDTH   (AW),
    .INST_LATENCY (INST_LAT),
    .DATA_LATENCY (DATA_LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_mem_addr       (inst_mem_addr),
    .inst_addr_valid     (inst_addr_valid),
    .inst_mem_valid      (inst_mem_valid),
    .inst_mem_data       (inst_mem_data),
    .data_mem_addr       (data_mem_addr),
    .data_mem_addr_valid (data_mem_addr_valid),
    .data_mem_rw         (data_mem_rw),
    .data_mem_data_w     (data_mem_data_w),
    .data_mem_data_r     (data_mem_data_r),
    .data_mem_ready      (data_mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'(a[AW+2:3]);
  endfunction

  // One data transaction; optionally moves the fetch PC in the ready cycle.
  task automatic data_req(input string tag, input logic rw, input logic [63:0] addr,
                          input logic [63:0] wd, input logic fetch_on_ready,
                          input logic [63:0] faddr);
    int k;
    bit seen;
    logic [63:0] exp;
    @(negedge clk);
    data_mem_addr       = addr;
    data_mem_rw         = rw;
    data_mem_data_w     = wd;
    data_mem_addr_valid = 1'b1;
    if (!rw) exp_q.push_back(model[idx_of(addr)]);
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (data_mem_ready) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(k), 64'(DATA_LAT));
    data_mem_addr_valid = 1'b0;
    if (fetch_on_ready) begin
      inst_mem_addr   = faddr;
      inst_addr_valid = 1'b1;
    end
    if (!rw) begin
      exp = exp_q.pop_front();
      check_eq({tag, "_rdata"}, data_mem_data_r, exp);
      last_rd = exp;
    end else begin
      check_eq({tag, "_hold"}, data_mem_data_r, last_rd);
      if (seen) model[idx_of(addr)] = wd;
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(data_mem_ready), 64'd0);
  endtask

  // Move the PC: valid must be low this cycle and high with data next cycle.
  task automatic fetch_at(input string tag, input logic [63:0] a, input logic [31:0] exp);
    @(negedge clk);
    inst_mem_addr   = a;
    inst_addr_valid = 1'b1;
    #1;
    check_eq({tag, "_gap"}, 64'(inst_mem_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, "_vld"}, 64'(inst_mem_valid), 64'd1);
    check_eq({tag, "_dat"}, 64'(inst_mem_data), 64'(exp));
  endtask

  initial begin
    logic [63:0] old_w;
    int          pulses;
    rst                 = 1'b1;
    inst_mem_addr       = 64'd0;
    inst_addr_valid     = 1'b0;
    data_mem_addr       = 64'd0;
    data_mem_addr_valid = 1'b0;
    data_mem_rw         = 1'b0;
    data_mem_data_w     = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ivalid", 64'(inst_mem_valid), 64'd0);
    check_eq("rst_idata", 64'(inst_mem_data), 64'd0);
    check_eq("rst_ready", 64'(data_mem_ready), 64'd0);
    check_eq("rst_rdata", data_mem_data_r, 64'd0);
    rst = 1'b0;

    // Preload and instruction fetch of both halves.
    data_req("pre0", 1'b1, 64'h0, 64'h0000_0013_0010_0093, 1'b0, 64'h0);
    data_req("pre100", 1'b1, 64'h100, 64'h1111_2222_3333_4444, 1'b0, 64'h0);
    fetch_at("f0", 64'h0, 32'h0010_0093);
    fetch_at("f4", 64'h4, 32'h0000_0013);
    @(negedge clk);
    check_eq("f4_hold", 64'(inst_mem_valid), 64'd1);

    // Fetch of 0x100 in the commit cycle of a write to 0x100 sees old data.
    old_w = model[idx_of(64'h100)];
    data_req("col", 1'b1, 64'h100, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h100);
    check_eq("col_fvld", 64'(inst_mem_valid), 64'd1);
    check_eq("col_fdat", 64'(inst_mem_data), 64'(old_w[31:0]));
    fetch_at("f4b", 64'h4, 32'h0000_0013);
    fetch_at("refetch", 64'h100, 32'hCAFE_F00D);
    fetch_at("f104", 64'h104, 32'hDEAD_BEEF);
    data_req("rd107", 1'b0, 64'h107, 64'h0, 1'b0, 64'h0);

    // Write aborted in BUSY: no pulse, memory keeps prior contents.
    data_req("w200", 1'b1, 64'h200, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
    @(negedge clk);
    data_mem_addr       = 64'h200;
    data_mem_rw         = 1'b1;
    data_mem_data_w     = 64'hFFFF_0000_FFFF_0000;
    data_mem_addr_valid = 1'b1;
    @(negedge clk);
    data_mem_addr_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_mem_ready) pulses++;
    end
    check_eq("abort_ready", 64'(pulses), 64'd0);
    data_req("rd200", 1'b0, 64'h200, 64'h0, 1'b0, 64'h0);

    // Reset in the RESP cycle of a write.
    data_req("w300", 1'b1, 64'h300, 64'hAAAA_5555_0F0F_F0F0, 1'b0, 64'h0);
    @(negedge clk);
    data_mem_addr       = 64'h300;
    data_mem_rw         = 1'b1;
    data_mem_data_w     = 64'h0BAD_0BAD_0BAD_0BAD;
    data_mem_addr_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rstresp_ready", 64'(data_mem_ready), 64'd0);
    @(negedge clk);
    rst                 = 1'b0;
    data_mem_addr_valid = 1'b0;
    #1;
    check_eq("rstrel_ready", 64'(data_mem_ready), 64'd0);
    check_eq("rstrel_ivalid", 64'(inst_mem_valid), 64'd0);
    check_eq("rstrel_idata", 64'(inst_mem_data), 64'd0);
    check_eq("rstrel_rdata", data_mem_data_r, 64'd0);
    last_rd = 64'd0;
    data_req("rd300", 1'b0, 64'h300, 64'h0, 1'b0, 64'h0);

    // Address wrap above ADDR_WIDTH+2.
    data_req("w8000", 1'b1, 64'h8000, 64'h5, 1'b0, 64'h0);
    data_req("rd0", 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
